// File: rtl/hybrid_seq_pkg.sv
// Shared types and helpers for the hybrid filter sequencer.
//   seq_state_t : sequencer FSM states (IDLE, FILL, SETTLE, RUN)
//   ValidDelay  : number of downsampled samples from start-up until the
//                 filter output is valid. The top-level output delay
//                 alignment uses the same function.
package hybrid_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_FILL   = 2'd1,
    SEQ_SETTLE = 2'd2,
    SEQ_RUN    = 2'd3
  } seq_state_t;

  // Fill depth, plus two register stages, plus the extra lookahead adder-tree
  // layers. The extra layers count only when that tree is deeper than the
  // lookback tree.
  function automatic int ValidDelay(input int ds_depth, input int ahead, input int back);
    return ds_depth + 2 + ((ahead > back) ? ahead : 0);
  endfunction

endpackage

// File: rtl/hybrid_sequencer_mod_counter.sv
// mod_counter: modulo-MOD up-counter with asynchronous active-low reset.
//   clk   : clock
//   rst   : asynchronous reset, active-low
//   clr   : synchronous clear to 0 (priority over en)
//   en    : count enable
//   count : current value, 0..MOD-1
//   wrap  : combinational, high when en=1 and count=MOD-1 (next value wraps to 0)
// With MOD==1 the counter is constant 0 and wrap equals en.
module mod_counter #(
  parameter int MOD = 6,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q;

  assign count = count_q;
  assign wrap  = en && (count_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == LAST) ? '0 : count_q + ONE;
    end
  end

endmodule

// File: rtl/hybrid_sequencer.sv
// hybrid_sequencer: single-clock sequencer for the two-stage hybrid filter.
// A phase counter and clock enables replace a derived downsample clock.
//   clkRecurse : recursion-rate clock
//   rst        : asynchronous reset, active-low
//   enable     : 1 runs the sequence, 0 freezes all state
//   resync     : one-cycle pulse that restarts the sequence from phase 0
//   phase      : position within the downsample period, 0..DSR2-1
//   ds_en      : one-cycle enable, issued once per downsampled sample
//   ds_clk     : square-wave phase marker, high while phase < DSR2/2
//   compute_en : gates the recursion inputs once the lookahead register is full
//   valid      : filter output valid, after the pipeline has settled
//   ds_count   : number of ds_en pulses since start, saturating at VALID_DELAY
//   state      : current FSM state, for debug
// compute_en and valid are level flags, not handshakes. Once set, each stays
// high until rst or resync clears it.
module hybrid_sequencer
  import hybrid_seq_pkg::*;
#(
  parameter  int DSR2            = 6,
  parameter  int DS_DEPTH        = 6,
  parameter  int LUT_AHEAD_DELAY = 2,
  parameter  int LUT_BACK_DELAY  = 1,
  localparam int VALID_DELAY     = ValidDelay(DS_DEPTH, LUT_AHEAD_DELAY, LUT_BACK_DELAY),
  localparam int CW              = $clog2(VALID_DELAY + 1),
  localparam int PW              = (DSR2 > 1) ? $clog2(DSR2) : 1
) (
  input  logic          clkRecurse,
  input  logic          rst,
  input  logic          enable,
  input  logic          resync,
  output logic [PW-1:0] phase,
  output logic          ds_en,
  output logic          ds_clk,
  output logic          compute_en,
  output logic          valid,
  output logic [CW-1:0] ds_count,
  output seq_state_t    state
);

  localparam logic [CW-1:0] VD_C   = CW'(VALID_DELAY);
  localparam logic [CW-1:0] DSD_C  = CW'(DS_DEPTH);
  localparam logic [CW-1:0] CNT1   = CW'(1);
  localparam logic [PW-1:0] PH1    = PW'(1);
  localparam logic [PW-1:0] HALF_C = PW'(DSR2 / 2);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;
  logic          valid_q, valid_d;
  logic          dsclk_q, dsclk_d;

  logic          ph_en;
  logic          ph_wrap;
  logic [PW-1:0] ph_next;

  // ds_clk level for a given phase. A one-cycle period has no low half, so
  // the marker stays high whenever the sequence is active.
  function automatic logic phase_high(input logic [PW-1:0] p);
    return (DSR2 == 1) || (p < HALF_C);
  endfunction

  assign ph_en   = (state_q != SEQ_IDLE) && enable;
  assign ph_next = ph_wrap ? '0 : phase + PH1;

  mod_counter #(
    .MOD (DSR2),
    .W   (PW)
  ) u_phase (
    .clk   (clkRecurse),
    .rst   (rst),
    .clr   (resync),
    .en    (ph_en),
    .count (phase),
    .wrap  (ph_wrap)
  );

  // Decoded directly from registers. A resync in the same cycle leaves this
  // pulse visible but keeps it out of ds_count.
  assign ds_en = ph_en && (phase == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ce_d    = ce_q;
    valid_d = valid_q;
    dsclk_d = dsclk_q;
    if (resync) begin
      state_d = enable ? SEQ_FILL : SEQ_IDLE;
      cnt_d   = '0;
      ce_d    = 1'b0;
      valid_d = 1'b0;
      dsclk_d = 1'b0;
    end else if (enable) begin
      if (state_q == SEQ_IDLE) begin
        // Leaving IDLE: the first FILL cycle sits at phase 0.
        state_d = SEQ_FILL;
        dsclk_d = phase_high('0);
      end else begin
        dsclk_d = phase_high(ph_next);
        if (ds_en && (cnt_q != VD_C)) begin
          cnt_d = cnt_q + CNT1;
        end
        // Transitions key on the count value being written at this edge, so
        // the flags rise one cycle after the ds_en that completes the count.
        if ((state_q == SEQ_FILL) && (cnt_d == DSD_C)) begin
          state_d = SEQ_SETTLE;
          ce_d    = 1'b1;
        end
        if ((state_q == SEQ_SETTLE) && (cnt_d == VD_C)) begin
          state_d = SEQ_RUN;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkRecurse or negedge rst) begin
    if (!rst) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      valid_q <= 1'b0;
      dsclk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      valid_q <= valid_d;
      dsclk_q <= dsclk_d;
    end
  end

  assign ds_clk     = dsclk_q;
  assign compute_en = ce_q;
  assign valid      = valid_q;
  assign ds_count   = cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hybrid_sequencer.sv
// Testbench for hybrid_sequencer.
// u_dut0 uses the default parameters: DSR2=6, DS_DEPTH=6, VALID_DELAY=10.
// u_dut1 uses DSR2=1, DS_DEPTH=3, AHEAD=1, BACK=1, which gives VALID_DELAY=5.
// Each expected output snapshot is tagged with its absolute cycle and pushed
// into exp_q. A monitor on the falling edge pops each entry in its cycle and
// compares it with the outputs of the selected instance.
// Relative cycle 0 is the first FILL cycle of each scenario.
module tb_hybrid_sequencer;
  import hybrid_seq_pkg::*;

  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, rs0;
  logic [2:0] ph0;
  logic       dsen0, dsclk0, ce0, v0;
  logic [3:0] cnt0;
  seq_state_t st0;

  logic       rst1, en1, rs1;
  logic [0:0] ph1;
  logic       dsen1, dsclk1, ce1, v1;
  logic [2:0] cnt1;
  seq_state_t st1;

  hybrid_sequencer u_dut0 (
    .clkRecurse (clk),
    .rst        (rst0),
    .enable     (en0),
    .resync     (rs0),
    .phase      (ph0),
    .ds_en      (dsen0),
    .ds_clk     (dsclk0),
    .compute_en (ce0),
    .valid      (v0),
    .ds_count   (cnt0),
    .state      (st0)
  );

  hybrid_sequencer #(
    .DSR2            (1),
    .DS_DEPTH        (3),
    .LUT_AHEAD_DELAY (1),
    .LUT_BACK_DELAY  (1)
  ) u_dut1 (
    .clkRecurse (clk),
    .rst        (rst1),
    .enable     (en1),
    .resync     (rs1),
    .phase      (ph1),
    .ds_en      (dsen1),
    .ds_clk     (dsclk1),
    .compute_en (ce1),
    .valid      (v1),
    .ds_count   (cnt1),
    .state      (st1)
  );

  int cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // ---------------- scoreboard ----------------
  // Entry layout: [32] dut select, [31:29] scenario, [28:13] absolute cycle,
  // [12:0] {ds_en, phase[2:0], ds_clk, compute_en, valid, ds_count[3:0], state[1:0]}
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int base   = 0;
  int scen   = 0;

  function automatic logic [W-1:0] mk(input logic sel, input int sc, input int c,
                                      input int e, input int ph, input int k,
                                      input int ce, input int v, input int cnt, input int st);
    return {sel, 3'(sc), 16'(c), 1'(e), 3'(ph), 1'(k), 1'(ce), 1'(v), 4'(cnt), 2'(st)};
  endfunction

  function automatic logic [12:0] act(input logic sel);
    if (sel)
      return {dsen1, 2'b00, ph1, dsclk1, ce1, v1, 1'b0, cnt1, 2'(st1)};
    else
      return {dsen0, ph0, dsclk0, ce0, v0, cnt0, 2'(st0)};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [12:0]  a;
    while (exp_q.size() > 0 && int'(exp_q[0][28:13]) <= cyc_abs) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(e[28:13]) != cyc_abs) begin
        errors++;
        $display("FAIL s%0d missed_cycle dut%0d: got cycle=%0d want cycle=%0d",
                 e[31:29], e[32], cyc_abs, e[28:13]);
      end else begin
        a = act(e[32]);
        if (a !== e[12:0]) begin
          errors++;
          $display("FAIL s%0d cyc%0d dut%0d: got en=%0d ph=%0d clk=%0d ce=%0d v=%0d cnt=%0d st=%0d want en=%0d ph=%0d clk=%0d ce=%0d v=%0d cnt=%0d st=%0d",
                   e[31:29], e[28:13], e[32],
                   a[12], a[11:9], a[8], a[7], a[6], a[5:2], a[1:0],
                   e[12], e[11:9], e[8], e[7], e[6], e[5:2], e[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    while (cyc_abs < base + r) step();
  endtask

  task automatic push(input logic sel, input int rel, input int e, input int ph, input int k,
                      input int ce, input int v, input int cnt, input int st);
    exp_q.push_back(mk(sel, scen, base + rel, e, ph, k, ce, v, cnt, st));
  endtask

  task automatic reset_all();
    rst0 = 1'b0; rst1 = 1'b0;
    en0  = 1'b0; en1  = 1'b0;
    rs0  = 1'b0; rs1  = 1'b0;
    step();
    base = cyc_abs;
    push(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst0 = 1'b1; rst1 = 1'b1;
  endtask

  // Raise enable during an IDLE cycle; the following cycle is FILL cycle 0.
  task automatic start(input logic sel);
    step();
    base = cyc_abs + 1;
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    push(sel, -1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    en0  = 1'b0; en1  = 1'b0;
    rs0  = 1'b0; rs1  = 1'b0;

    // Scenario 1: plain start-up, then an asynchronous reset in RUN and a restart.
    scen = 1;
    reset_all();
    start(1'b0);
    push(1'b0,  0, 1, 0, 1, 0, 0,  0, 1);
    push(1'b0,  3, 0, 3, 0, 0, 0,  1, 1);
    push(1'b0,  6, 1, 0, 1, 0, 0,  1, 1);
    push(1'b0,  7, 0, 1, 1, 0, 0,  2, 1);
    push(1'b0, 30, 1, 0, 1, 0, 0,  5, 1);
    push(1'b0, 31, 0, 1, 1, 1, 0,  6, 2);
    push(1'b0, 54, 1, 0, 1, 1, 0,  9, 2);
    push(1'b0, 55, 0, 1, 1, 1, 1, 10, 3);
    push(1'b0, 61, 0, 1, 1, 1, 1, 10, 3);
    wait_rel(63);
    rst0 = 1'b0;
    push(1'b0, 63, 0, 0, 0, 0, 0, 0, 0);
    step();
    push(1'b0, 64, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst0 = 1'b1;
    push(1'b0, 65, 0, 0, 0, 0, 0, 0, 0);
    base = cyc_abs + 1;
    push(1'b0,  0, 1, 0, 1, 0, 0,  0, 1);
    push(1'b0,  6, 1, 0, 1, 0, 0,  1, 1);
    push(1'b0, 31, 0, 1, 1, 1, 0,  6, 2);
    push(1'b0, 55, 0, 1, 1, 1, 1, 10, 3);
    wait_rel(57);

    // Scenario 2: enable low for cycles 10..19.
    scen = 2;
    reset_all();
    start(1'b0);
    push(1'b0,  9, 0, 3, 0, 0, 0,  2, 1);
    push(1'b0, 10, 0, 4, 0, 0, 0,  2, 1);
    push(1'b0, 12, 0, 4, 0, 0, 0,  2, 1);
    push(1'b0, 19, 0, 4, 0, 0, 0,  2, 1);
    push(1'b0, 20, 0, 4, 0, 0, 0,  2, 1);
    push(1'b0, 22, 1, 0, 1, 0, 0,  2, 1);
    push(1'b0, 23, 0, 1, 1, 0, 0,  3, 1);
    push(1'b0, 40, 1, 0, 1, 0, 0,  5, 1);
    push(1'b0, 41, 0, 1, 1, 1, 0,  6, 2);
    push(1'b0, 64, 1, 0, 1, 1, 0,  9, 2);
    push(1'b0, 65, 0, 1, 1, 1, 1, 10, 3);
    wait_rel(10);
    en0 = 1'b0;
    wait_rel(20);
    en0 = 1'b1;
    wait_rel(66);

    // Scenario 3: resync pulse at cycle 40, during SETTLE.
    scen = 3;
    reset_all();
    start(1'b0);
    push(1'b0, 40, 0, 4, 0, 1, 0,  7, 2);
    push(1'b0, 41, 1, 0, 0, 0, 0,  0, 1);
    push(1'b0, 42, 0, 1, 1, 0, 0,  1, 1);
    push(1'b0, 71, 1, 0, 1, 0, 0,  5, 1);
    push(1'b0, 72, 0, 1, 1, 1, 0,  6, 2);
    push(1'b0, 95, 1, 0, 1, 1, 0,  9, 2);
    push(1'b0, 96, 0, 1, 1, 1, 1, 10, 3);
    wait_rel(40);
    rs0 = 1'b1;
    step();
    rs0 = 1'b0;
    wait_rel(97);

    // Scenario 4: resync in the same cycle as the 6th ds_en (cycle 30).
    scen = 4;
    reset_all();
    start(1'b0);
    push(1'b0, 30, 1, 0, 1, 0, 0, 5, 1);
    push(1'b0, 31, 1, 0, 0, 0, 0, 0, 1);
    push(1'b0, 32, 0, 1, 1, 0, 0, 1, 1);
    push(1'b0, 37, 1, 0, 1, 0, 0, 1, 1);
    push(1'b0, 61, 1, 0, 1, 0, 0, 5, 1);
    push(1'b0, 62, 0, 1, 1, 1, 0, 6, 2);
    wait_rel(30);
    rs0 = 1'b1;
    step();
    rs0 = 1'b0;
    wait_rel(63);

    // Scenario 5: DSR2=1 instance, so ds_en fires every cycle.
    scen = 5;
    reset_all();
    start(1'b1);
    push(1'b1, 0, 1, 0, 1, 0, 0, 0, 1);
    push(1'b1, 2, 1, 0, 1, 0, 0, 2, 1);
    push(1'b1, 3, 1, 0, 1, 1, 0, 3, 2);
    push(1'b1, 4, 1, 0, 1, 1, 0, 4, 2);
    push(1'b1, 5, 1, 0, 1, 1, 1, 5, 3);
    push(1'b1, 8, 1, 0, 1, 1, 1, 5, 3);
    wait_rel(9);

    // ---------------- final report ----------------
    step();
    step();
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL s%0d unchecked dut%0d: got no sample, want check at cycle %0d",
               e[31:29], e[32], e[28:13]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
